in_ram_rd_ctrl: RTL
===================

Name: in_ram_rd_ctrl

Overview:
Read-side sequencer for the matrix input buffer RAM (160-bit words, 64 entries, 1-cycle registered read). On a start command it issues a burst of read addresses and absorbs the RAM's fixed 1-cycle read latency. It streams the returned words to the downstream matrix datapath over a valid/ready interface with full backpressure support. It sits between the input RAM's read port and the compute array, and is the counterpart of the RAM write/fill path.

Parameters:
DWIDTH, 160, RAM word width and stream data width.
AWIDTH, 6, RAM address width.
WORDS, 64, RAM depth; addresses wrap modulo WORDS.

Ports:
clk  in  1  single clock, shared with the input RAM.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle command strobe; sampled only when busy=0.
base_addr  in  AWIDTH  first RAM address of the burst.
len  in  AWIDTH+1  number of words in the burst, 0..WORDS.
busy  out  1  high from the accepted start until the final beat is accepted.
done  out  1  one-cycle pulse when the burst completes.
raddr  out  AWIDTH  RAM read address (to RAM raddr).
rdat  in  DWIDTH  RAM read data; valid exactly 1 cycle after raddr is presented with a read issued.
m_valid  out  1  stream data valid.
m_data  out  DWIDTH  stream data.
m_last  out  1  marks the final word of the burst; qualified by m_valid.
m_ready  in  1  downstream accept; a beat transfers when m_valid & m_ready.

Behaviour:
- Reset (asynchronous, immediate): busy=0, done=0, raddr=0, m_valid=0, m_last=0, m_data=0. Issue and accept counters cleared, FIFO emptied, in-flight flag cleared. A reset mid-burst abandons the burst; no done pulse.
- FSM states:
  - IDLE: start & len!=0 -> RUN; latch base_addr and len, busy=1 next cycle.
  - IDLE: start & len==0 -> DONE with no beats.
  - RUN: after the final beat is accepted -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
  - start while busy=1 is ignored.
- Issue rule:
  - A read is issued in a cycle when state=RUN, issued<len, and (fifo_count + inflight) < 2.
  - On issue: raddr=(base_addr+issued) mod WORDS, registered; inflight=1 next cycle; issued increments.
  - The address wraps 63->0 naturally (AWIDTH-bit add, carry dropped).
- Return path: when inflight=1, rdat is pushed into a 2-entry FIFO in that cycle. The credit rule guarantees the FIFO never overflows, so no push is dropped.
- The FIFO head drives m_data/m_valid. m_last=1 when the head entry's sequence index == len-1; a tag bit is stored per entry.
- Throughput: one word per cycle sustained while m_ready=1.
- Latency: start -> first raddr valid at cycle +1; first m_valid at cycle +3. Cycle +2 is RAM read; the FIFO output is registered.
- Backpressure:
  - m_data and m_last stay stable while m_valid=1 & m_ready=0.
  - m_valid never drops without a transfer.
- Simultaneous push and pop on the FIFO in one cycle is legal; the count is unchanged.
- done is asserted the cycle after the last beat transfer; busy falls in that same cycle.
- len=WORDS (64) reads all entries once, base_addr first, with wrap.
- raddr holds its last value when not issuing. The RAM read is unconditional, so stale reads are harmless and not pushed.

Decomposition:
- Package in_ram_pkg holds DWIDTH, AWIDTH, WORDS defaults, the FSM state encoding (IDLE/RUN/DONE), and the LEN_W=AWIDTH+1 constant.
- One sub-module: rd_skid_fifo, a 2-entry FIFO of {last, data} with push/pop/count and async reset. The controller instantiates it once.

Test Plan:
- base=0, len=4, m_ready=1 constant, RAM preloaded mem[i]=i -> beats 0,1,2,3 on consecutive cycles; first m_valid at start+3; m_last on beat 3; done pulse 1 cycle after beat 3; busy high for exactly that span.
- base=62, len=4 -> raddr sequence 62,63,0,1; data mem[62],mem[63],mem[0],mem[1]; m_last on the fourth beat.
- len=8, m_ready toggling 1,0,0,1,0,1... -> all 8 words delivered in order, none duplicated or dropped; m_data stable during every stall; FIFO count never exceeds 2.
- len=0 start -> no m_valid; done pulses at start+1; busy stays 0 or rises for one cycle only; the next start with len=2 then works normally.
- start asserted again mid-burst (len=6, second start at beat 2 with base=10) -> ignored; exactly 6 beats from the original base.
- rst asserted at beat 3 of len=10 -> all outputs immediately 0, no done; a subsequent start base=5, len=3 delivers mem[5..7] correctly.

Source files
------------

// File: rtl/in_ram_rd_ctrl_pkg.sv
// Shared constants and types for the input-RAM read sequencer.
package in_ram_pkg;

    localparam int DWIDTH = 160;        // RAM word / stream data width
    localparam int AWIDTH = 6;          // RAM address width
    localparam int WORDS  = 64;         // RAM depth, addresses wrap modulo WORDS
    localparam int LEN_W  = AWIDTH + 1; // burst length 0..WORDS needs one extra bit

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/in_ram_rd_ctrl_if.sv
// Command, RAM read port and output stream of the read sequencer.
// master = the sequencer, slave = whoever drives commands, RAM data and m_ready.
interface in_ram_rd_ctrl_if;
    import in_ram_pkg::*;

    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [AWIDTH-1:0] raddr;
    logic [DWIDTH-1:0] rdat;
    logic              m_valid;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  start, base_addr, len, rdat, m_ready,
        output busy, done, raddr, m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, len, rdat, m_ready,
        input  busy, done, raddr, m_valid, m_data, m_last
    );

endinterface

// File: rtl/in_ram_rd_ctrl_rd_skid_fifo.sv
// Two-entry FIFO of {last, data} holding RAM words that came back while
// downstream was stalled. Head entry is a register, so the stream output
// has no combinational path from rdat.
module rd_skid_fifo
    import in_ram_pkg::*;
#(
    parameter int W = DWIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [1:0][W-1:0] r_mem;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // Pop only a real entry; a push into a full FIFO is accepted only
    // if the head leaves in the same cycle.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem   <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/in_ram_rd_ctrl.sv
// Read-side sequencer for the matrix input RAM: issues a burst of read
// addresses, absorbs the 1-cycle RAM latency and streams words out over
// valid/ready with full backpressure.
//
// r_raddr always points at the next word to read, so a read "issues" in
// the cycle the address is already on the RAM port; its data returns one
// cycle later (r_inflight) and is pushed into the skid FIFO. The credit
// check counts this cycle's pop, which keeps one word per cycle flowing
// while still guaranteeing the 2-entry FIFO can never overflow.
module in_ram_rd_ctrl
    import in_ram_pkg::*;
(
    input logic               clk,
    input logic               rst,
    in_ram_rd_ctrl_if.master  bus
);

    localparam logic [LEN_W-1:0]  ONE_L = LEN_W'(1);
    localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_pushed;
    logic [AWIDTH-1:0]  r_raddr;
    logic               r_inflight;

    logic               w_start_ok;
    logic               w_issue;
    logic               w_pop;
    logic               w_last_beat;
    logic               w_push_last;
    logic               w_fifo_valid;
    logic [1:0]         w_fifo_cnt;
    logic [DWIDTH:0]    w_head;
    logic [2:0]         w_credit;

    // start is honoured whenever not busy (IDLE or the DONE cycle).
    assign w_start_ok  = (r_state != ST_RUN) & bus.start;
    assign w_pop       = w_fifo_valid & bus.m_ready;
    assign w_last_beat = w_pop & w_head[DWIDTH];

    // Occupancy after this cycle's pop, including the word returning now.
    // A pop implies count>=1, so the subtraction cannot wrap.
    assign w_credit = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == ST_RUN) & (r_issued < r_len) & (w_credit < 3'd2);

    // Tag the word whose sequence index is len-1.
    assign w_push_last = (r_pushed == (r_len - ONE_L));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus busy/done decode.
    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    w_state_nxt = (bus.len != '0) ? ST_RUN : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Burst bookkeeping: latch the command, advance the read address and
    // track issued / returned word counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_pushed   <= '0;
            r_raddr    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_ok) begin
                if (bus.len != '0) begin
                    r_len    <= bus.len;
                    r_issued <= '0;
                    r_pushed <= '0;
                    r_raddr  <= bus.base_addr;
                end
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + ONE_L;
                    // Stay on the final address once the burst is fully issued.
                    if ((r_issued + ONE_L) < r_len) begin
                        r_raddr <= r_raddr + ONE_A;
                    end
                end
                if (r_inflight) begin
                    r_pushed <= r_pushed + ONE_L;
                end
            end
        end
    end

    rd_skid_fifo #(
        .W (DWIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  ({w_push_last, bus.rdat}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    assign bus.raddr   = r_raddr;
    assign bus.m_valid = w_fifo_valid;
    assign bus.m_data  = w_head[DWIDTH-1:0];
    assign bus.m_last  = w_fifo_valid & w_head[DWIDTH];

endmodule
